// File: rtl/alu_mul_seq_if.sv
// ---------------------------------------------------------------------------
// alu_mul_seq_if
//   Bundles every non-clock signal of the multiply sequencer.
//
//   master : the core-side environment (core plus the shared alu). It
//            issues multiply requests and core ALU ops, returns the alu
//            result, and observes status, product and the alu command.
//   slave  : the sequencer itself.
//
//   START, IN_MCAND, IN_MPLIER  multiply request and operands
//   BUSY, DONE                  status (BUSY: core keeps off the alu)
//   OUT_HI, OUT_LO              product halves
//   CPU_INSTR/A/B/Cin           core's ALU request (used only in IDLE)
//   ALU_INSTR/A/B/Cin           command sent to the shared alu
//   ALU_OUT, ALU_Cout           shared alu result
// ---------------------------------------------------------------------------
interface alu_mul_seq_if #(
    parameter int DWIDTH = 8,
    parameter int IWIDTH = 4
);
    logic              START;
    logic [DWIDTH-1:0] IN_MCAND;
    logic [DWIDTH-1:0] IN_MPLIER;
    logic              BUSY;
    logic              DONE;
    logic [DWIDTH-1:0] OUT_HI;
    logic [DWIDTH-1:0] OUT_LO;

    logic [IWIDTH-1:0] CPU_INSTR;
    logic [DWIDTH-1:0] CPU_A;
    logic [DWIDTH-1:0] CPU_B;
    logic              CPU_Cin;

    logic [IWIDTH-1:0] ALU_INSTR;
    logic [DWIDTH-1:0] ALU_A;
    logic [DWIDTH-1:0] ALU_B;
    logic              ALU_Cin;
    logic [DWIDTH-1:0] ALU_OUT;
    logic              ALU_Cout;

    modport master (
        output START, IN_MCAND, IN_MPLIER,
        output CPU_INSTR, CPU_A, CPU_B, CPU_Cin,
        output ALU_OUT, ALU_Cout,
        input  BUSY, DONE, OUT_HI, OUT_LO,
        input  ALU_INSTR, ALU_A, ALU_B, ALU_Cin
    );

    modport slave (
        input  START, IN_MCAND, IN_MPLIER,
        input  CPU_INSTR, CPU_A, CPU_B, CPU_Cin,
        input  ALU_OUT, ALU_Cout,
        output BUSY, DONE, OUT_HI, OUT_LO,
        output ALU_INSTR, ALU_A, ALU_B, ALU_Cin
    );
endinterface

// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq
//   Unsigned DWIDTH x DWIDTH -> 2*DWIDTH shift-and-add multiplier that
//   borrows the shared alu for its additions. While idle, the core's ALU
//   request is passed straight through to the alu with no added latency.
//
//   CLK   : clock, rising edge
//   nRST  : asynchronous active-low reset
//   bus   : alu_mul_seq_if.slave (request, status, product, core and
//           alu ALU ports)
// ---------------------------------------------------------------------------
module alu_mul_seq #(
    parameter int DWIDTH = 8,
    parameter int IWIDTH = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    alu_mul_seq_if.slave  bus
);
    localparam int CWIDTH = $clog2(DWIDTH + 1);
    localparam logic [IWIDTH-1:0] OP_ADD = IWIDTH'(4'h5);
    localparam logic [IWIDTH-1:0] OP_NOP = IWIDTH'(4'hF);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        SHIFT,
        FIN
    } state_e;

    state_e            state_q, state_d;
    logic [DWIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [DWIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [DWIDTH-1:0] mc_q, mc_d;
    logic              c_q, c_d;
    logic [CWIDTH-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Next-state and datapath update.
    // ACC_LO doubles as the multiplier shift register: its bit 0 is the
    // multiplier bit being processed, so bit 1 decides the step after a
    // shift.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would infer a latch.
        state_d  = state_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        mc_d     = mc_q;
        c_d      = c_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    acc_hi_d = '0;
                    acc_lo_d = bus.IN_MPLIER;
                    mc_d     = bus.IN_MCAND;
                    c_d      = 1'b0;
                    cnt_d    = CWIDTH'(DWIDTH);
                    state_d  = bus.IN_MPLIER[0] ? ADD : SHIFT;
                end
            end
            ADD: begin
                acc_hi_d = bus.ALU_OUT;
                c_d      = bus.ALU_Cout;
                state_d  = SHIFT;
            end
            SHIFT: begin
                // Carry from the preceding add enters the top of ACC_HI.
                {c_d, acc_hi_d, acc_lo_d} = {1'b0, c_q, acc_hi_q, acc_lo_q[DWIDTH-1:1]};
                cnt_d = cnt_q - CWIDTH'(1);
                if (cnt_q == CWIDTH'(1)) begin
                    state_d = FIN;
                end else begin
                    state_d = acc_lo_q[1] ? ADD : SHIFT;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up
        // exactly with the state they describe.
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mc_q     <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q  <= state_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            mc_q     <= mc_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Shared alu command: core pass-through in IDLE, ADD of the running
    // upper half and multiplicand in ADD, NOP with zero operands otherwise.
    always_comb begin
        bus.ALU_INSTR = OP_NOP;
        bus.ALU_A     = '0;
        bus.ALU_B     = '0;
        bus.ALU_Cin   = 1'b0;
        case (state_q)
            IDLE: begin
                bus.ALU_INSTR = bus.CPU_INSTR;
                bus.ALU_A     = bus.CPU_A;
                bus.ALU_B     = bus.CPU_B;
                bus.ALU_Cin   = bus.CPU_Cin;
            end
            ADD: begin
                bus.ALU_INSTR = OP_ADD;
                bus.ALU_A     = acc_hi_q;
                bus.ALU_B     = mc_q;
            end
            default: begin
            end
        endcase
    end

    assign bus.BUSY   = busy_q;
    assign bus.DONE   = done_q;
    assign bus.OUT_HI = acc_hi_q;
    assign bus.OUT_LO = acc_lo_q;
endmodule
